shift_reg_n: RTL and testbench

Parametrised shift register with a built-in multi-cycle shift sequencer, replacing fixed-width load-only registers in the datapath. It supports parallel load, single-step serial shift, and Start-triggered k-bit shifts with Busy/Done handshakes. Four fill modes are provided: serial, zero, arithmetic and rotate. It serves as the shared register and shift unit for the multiplier and the SLC-3 shift instructions.

---
 rtl/shift_reg_n.sv | 116 +++++++++++
 tb/tb_shift_reg_n.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_n.sv
// rtl/shift_reg_n.sv - parametrised shift register with Start-triggered multi-step sequencer
// Define SHIFT_REG_N_LEFT_EN to build left-shift support; otherwise Dir is ignored.
module shift_reg_n #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  input  logic             Shift_In,
  input  logic             Shift_En,
  input  logic             Start,
  input  logic [CNT_W-1:0] Amount,
  input  logic             Dir,
  input  logic [1:0]       Mode,
  output logic             Busy,
  output logic             Done,
  output logic             Shift_Out,
  output logic [WIDTH-1:0] Data_Out
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             dir_q, dir_nxt;
  logic [1:0]       mode_q, mode_nxt;
  logic [WIDTH-1:0] data_q, data_nxt;
  logic             dir_live;

`ifdef SHIFT_REG_N_LEFT_EN
  assign dir_live = Dir;
`else
  logic unused_dir;
  assign unused_dir = Dir;
  assign dir_live   = 1'b0;
`endif

  // One shift step; fill bit chosen by mode, rotate reuses the expelled bit.
  function automatic logic [WIDTH-1:0] step_fn(input logic [WIDTH-1:0] v,
                                               input logic             d,
                                               input logic [1:0]       m,
                                               input logic             sin);
    logic fill;
    logic expelled;
    expelled = d ? v[WIDTH-1] : v[0];
    fill     = 1'b0;
    case (m)
      2'b00:   fill = sin;
      2'b01:   fill = 1'b0;
      2'b10:   fill = d ? 1'b0 : v[WIDTH-1];
      default: fill = expelled;
    endcase
`ifdef SHIFT_REG_N_LEFT_EN
    step_fn = d ? {v[WIDTH-2:0], fill} : {fill, v[WIDTH-1:1]};
`else
    step_fn = {fill, v[WIDTH-1:1]};
`endif
  endfunction

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      dir_q  <= 1'b0;
      mode_q <= 2'b00;
      data_q <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      dir_q  <= dir_nxt;
      mode_q <= mode_nxt;
      data_q <= data_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dir_nxt   = dir_q;
    mode_nxt  = mode_q;
    data_nxt  = data_q;
    if (Load) begin
      data_nxt  = D;
      cnt_nxt   = '0;
      state_nxt = IDLE;
    end else if (Start && state != SHIFT) begin
      dir_nxt   = dir_live;
      mode_nxt  = Mode;
      cnt_nxt   = Amount;
      state_nxt = (Amount != '0) ? SHIFT : DONE;
    end else if (state == SHIFT) begin
      data_nxt = step_fn(data_q, dir_q, mode_q, Shift_In);
      cnt_nxt  = cnt - 1'b1;
      if (cnt == CNT_W'(1))
        state_nxt = DONE;
    end else begin
      if (Shift_En)
        data_nxt = step_fn(data_q, dir_live, Mode, Shift_In);
      if (state == DONE)
        state_nxt = IDLE;
    end
  end

  assign Busy     = (state == SHIFT);
  assign Done     = (state == DONE);
  assign Data_Out = data_q;

`ifdef SHIFT_REG_N_LEFT_EN
  assign Shift_Out = (Busy ? dir_q : dir_live) ? data_q[WIDTH-1] : data_q[0];
`else
  assign Shift_Out = data_q[0];
`endif

endmodule

// File: tb/tb_shift_reg_n.sv
// tb/tb_shift_reg_n.sv - randomized self-checking bench for shift_reg_n against a queue-based model
// Honours SHIFT_REG_N_LEFT_EN the same way as the design.
module tb_shift_reg_n;

  localparam int W  = 16;
  localparam int CW = $clog2(W + 1);
  localparam int unsigned MASK = (32'd1 << W) - 1;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Load;
  logic [W-1:0]  D;
  logic          Shift_In;
  logic          Shift_En;
  logic          Start;
  logic [CW-1:0] Amount;
  logic          Dir;
  logic [1:0]    Mode;
  logic          Busy;
  logic          Done;
  logic          Shift_Out;
  logic [W-1:0]  Data_Out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clk = ~Clk;

  shift_reg_n #(.WIDTH(W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Load      (Load),
    .D         (D),
    .Shift_In  (Shift_In),
    .Shift_En  (Shift_En),
    .Start     (Start),
    .Amount    (Amount),
    .Dir       (Dir),
    .Mode      (Mode),
    .Busy      (Busy),
    .Done      (Done),
    .Shift_Out (Shift_Out),
    .Data_Out  (Data_Out)
  );

  // Model: register value plus a queue of pending {dir, mode} steps.
  int unsigned m_val;
  bit [2:0]    m_pend[$];
  bit          m_done;
  bit          m_ldir;

  function automatic int unsigned ref_step(int unsigned v, bit d, bit [1:0] m, bit sin);
    int unsigned msb = (v >> (W - 1)) & 1;
    int unsigned lsb = v & 1;
    int unsigned fill;
`ifndef SHIFT_REG_N_LEFT_EN
    d = 1'b0;
`endif
    case (m)
      2'd0:    fill = sin;
      2'd1:    fill = 0;
      2'd2:    fill = d ? 0 : msb;
      default: fill = d ? msb : lsb;
    endcase
    if (d) return ((v << 1) | fill) & MASK;
    return (v >> 1) | (fill << (W - 1));
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_val = 0;
    m_pend.delete();
    m_done = 0;
    m_ldir = 0;
  endtask

  task automatic model_advance();
    if (Load) begin
      m_val = D;
      m_pend.delete();
      m_done = 0;
    end else if (Start && m_pend.size() == 0) begin
      m_ldir = Dir;
      for (int i = 0; i < int'(Amount); i++) m_pend.push_back({Dir, Mode});
      m_done = (Amount == 0);
    end else if (m_pend.size() != 0) begin
      bit [2:0] e;
      e = m_pend.pop_front();
      m_val = ref_step(m_val, e[2], e[1:0], Shift_In);
      m_done = (m_pend.size() == 0);
    end else begin
      if (Shift_En) m_val = ref_step(m_val, Dir, Mode, Shift_In);
      m_done = 0;
    end
  endtask

  task automatic compare();
    bit ed;
    int unsigned exp_so;
    ed = (m_pend.size() != 0) ? m_ldir : Dir;
`ifndef SHIFT_REG_N_LEFT_EN
    ed = 1'b0;
`endif
    exp_so = ed ? ((m_val >> (W - 1)) & 1) : (m_val & 1);
    check("data", 32'(Data_Out), m_val);
    check("busy", 32'(Busy), 32'(m_pend.size() != 0));
    check("done", 32'(Done), 32'(m_done));
    check("shift_out", 32'(Shift_Out), exp_so);
  endtask

  task automatic tick();
    model_advance();
    @(posedge Clk);
    #1;
    compare();
  endtask

  task automatic do_load(input logic [W-1:0] val);
    Load = 1'b1;
    D = val;
    tick();
    Load = 1'b0;
  endtask

  task automatic do_start(input int amt, input logic d, input logic [1:0] m);
    Start = 1'b1;
    Amount = CW'(amt);
    Dir = d;
    Mode = m;
    tick();
    Start = 1'b0;
  endtask

  initial begin
    Reset = 1'b0; Load = 1'b0; D = '0; Shift_In = 1'b0; Shift_En = 1'b0;
    Start = 1'b0; Amount = '0; Dir = 1'b0; Mode = 2'b00;
    model_reset();
    #1;
    check("rst_data", 32'(Data_Out), 0);
    check("rst_busy", 32'(Busy), 0);
    check("rst_done", 32'(Done), 0);
    #12 Reset = 1'b1;
    tick();

    // Arithmetic right by 4 from 8001
    do_load(16'h8001);
    do_start(4, 1'b0, 2'b10);
    check("arith_busy_e0", 32'(Busy), 1);
    repeat (4) tick();
    check("arith_data", 32'(Data_Out), 32'h0000F800);
    check("arith_done", 32'(Done), 1);
    tick();
    check("arith_done_one_cycle", 32'(Done), 0);

    // Rotate by WIDTH restores the value
    do_load(16'h8001);
    do_start(16, 1'b1, 2'b11);
    repeat (15) tick();
    check("rot_busy_e15", 32'(Busy), 1);
    tick();
    check("rot_data", 32'(Data_Out), 32'h00008001);
    check("rot_done", 32'(Done), 1);
    tick();

    // Load at E2 aborts the sequence without Done
    do_load(16'h00F0);
    do_start(3, 1'b0, 2'b01);
    Dir = 1'b1; Mode = 2'b11; Amount = CW'(7);
    tick();
    Load = 1'b1; D = 16'h1234;
    tick();
    Load = 1'b0;
    check("abort_data", 32'(Data_Out), 32'h00001234);
    check("abort_busy", 32'(Busy), 0);
    check("abort_done", 32'(Done), 0);
    tick();
    check("abort_no_done", 32'(Done), 0);

    // Amount = 0, then back-to-back Start while Done
    do_start(0, 1'b0, 2'b01);
    check("zero_busy", 32'(Busy), 0);
    check("zero_done", 32'(Done), 1);
    check("zero_data", 32'(Data_Out), 32'h00001234);
    do_start(2, 1'b0, 2'b01);
    check("b2b_busy", 32'(Busy), 1);
    check("b2b_done", 32'(Done), 0);
    repeat (3) tick();
    do_start(0, 1'b0, 2'b00);
    tick();
    check("zero_done_cleared", 32'(Done), 0);

    // Serial fill via Shift_En
    do_load(16'h0000);
    Mode = 2'b00; Dir = 1'b0; Shift_In = 1'b1;
    Shift_En = 1'b1;
    repeat (3) tick();
    Shift_En = 1'b0;
    check("serial_data", 32'(Data_Out), 32'h0000E000);
    check("serial_sout", 32'(Shift_Out), 0);
`ifndef SHIFT_REG_N_LEFT_EN
    do_load(16'h0000);
    Dir = 1'b1;
    Shift_En = 1'b1;
    repeat (3) tick();
    Shift_En = 1'b0;
    check("serial_dir1_data", 32'(Data_Out), 32'h0000E000);
    check("serial_dir1_sout", 32'(Shift_Out), 0);
    Dir = 1'b0;
`endif

    // Asynchronous reset mid-sequence
    do_load(16'hBEEF);
    do_start(5, 1'b0, 2'b01);
    tick();
    #2 Reset = 1'b0;
    #1;
    check("async_rst_data", 32'(Data_Out), 0);
    check("async_rst_busy", 32'(Busy), 0);
    check("async_rst_done", 32'(Done), 0);
    model_reset();
    @(negedge Clk);
    Reset = 1'b1;
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      Load     = ($urandom_range(0, 99) < 4);
      D        = W'($urandom);
      Start    = ($urandom_range(0, 99) < 12);
      Amount   = CW'($urandom_range(0, (1 << CW) - 1));
      Dir      = 1'($urandom_range(0, 1));
      Mode     = 2'($urandom_range(0, 3));
      Shift_In = 1'($urandom_range(0, 1));
      Shift_En = ($urandom_range(0, 99) < 40);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
